// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
//   Shared definitions for the SPI DAC transmit path (MCP4911-class, 10-bit).
//   - Command word bit positions and frame length.
//   - FSM state encoding for spi2dac_tx.
//   - Sample record (shutdown flag + 10-bit offset-binary code).
//   - build_cmd(): assembles the 16-bit write command from a sample.
// ---------------------------------------------------------------------------
package dac_pkg;

  localparam int FRAME_BITS   = 16;
  localparam int DATA_W       = 10;

  // Command word layout, MSB first on the wire.
  localparam int CMD_WRITE    = 15;  // 0 = write to DAC register
  localparam int CMD_BUF      = 14;  // VREF input buffer enable
  localparam int CMD_GA       = 13;  // gain select, 1 = 1x
  localparam int CMD_SHDN     = 12;  // 0 = output shutdown
  localparam int CMD_DATA_MSB = 11;
  localparam int CMD_DATA_LSB = 2;

  // FSM encoding kept as plain constants so legacy code can share it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CS_HI = 2'd2;
  localparam logic [1:0] ST_LDAC  = 2'd3;

  typedef struct packed {
    logic              shdn_n;
    logic [DATA_W-1:0] code;
  } dac_sample_t;

  function automatic logic [FRAME_BITS-1:0] build_cmd(
    input logic        buf_bit,
    input logic        ga_n_bit,
    input dac_sample_t s
  );
    logic [FRAME_BITS-1:0] c;
    c                             = '0;
    c[CMD_WRITE]                  = 1'b0;
    c[CMD_BUF]                    = buf_bit;
    c[CMD_GA]                     = ga_n_bit;
    c[CMD_SHDN]                   = s.shdn_n;
    c[CMD_DATA_MSB:CMD_DATA_LSB]  = s.code;
    return c;
  endfunction

endpackage

// File: rtl/sck_divider.sv
// ---------------------------------------------------------------------------
// sck_divider
//   Half-period counter for an SPI master. While en is high it counts
//   CLK_DIV sysclk cycles per SCK phase and flags the last cycle of each
//   phase. The internal phase bit starts low (SCK idle low), so the first
//   completed phase requests a rising SCK edge and the next a falling one.
//   Dropping en restarts the count and the phase.
//
//   Ports:
//     sysclk    in   system clock
//     rst_n     in   asynchronous active-low reset
//     en        in   run the counter
//     half_done out  last cycle of the current half-period
//     sck_rise  out  half_done while SCK is low  -> drive SCK high next
//     sck_fall  out  half_done while SCK is high -> drive SCK low next
// ---------------------------------------------------------------------------
module sck_divider #(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic en,
  output logic half_done,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int             CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the clock edge, regardless of order.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half_done) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign half_done = en && (cnt == LAST);
  assign sck_rise  = half_done && !phase;
  assign sck_fall  = half_done &&  phase;

endmodule

// File: rtl/spi2dac_tx.sv
// ---------------------------------------------------------------------------
// spi2dac_tx
//   Frames a 10-bit offset-binary DAC code as a 16-bit MCP4911 write command,
//   shifts it MSB-first in SPI mode 0, then pulses LDAC to latch it.
//   A one-deep pending register holds a sample that arrives mid-frame; it is
//   launched on the first IDLE cycle after the current frame.
//
//   Frame timing (D = CLK_DIV), counted from the load cycle (cycle 0):
//     cycles 1 .. 32D        SHIFT : cs_n low, 16 bits of D low + D high SCK
//     next D cycles          CS_HI : cs_n high, sdi low
//     next D cycles          LDAC  : ld_n low
//     cycle 1 + 34D          IDLE  : busy low
//
//   Ports:
//     sysclk   in   system clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     data_in  in   [9:0] DAC code (offset binary)
//     load     in   single-cycle strobe capturing data_in / shdn_n
//     shdn_n   in   shutdown control, placed in command bit 12
//     dac_cs_n out  SPI chip select, active low
//     dac_sck  out  SPI clock, idles low
//     dac_sdi  out  SPI data to DAC
//     dac_ld_n out  DAC latch strobe, active low
//     busy     out  frame in progress (SHIFT, CS_HI or LDAC)
//     overrun  out  sticky: a pending sample was overwritten
//
//   All four SPI-side outputs come straight from flops, so they cannot glitch.
// ---------------------------------------------------------------------------
module spi2dac_tx
  import dac_pkg::*;
#(
  parameter int   CLK_DIV = 25,
  parameter logic BUF     = 1'b1,
  parameter logic GA_N    = 1'b1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [9:0]  data_in,
  input  logic        load,
  input  logic        shdn_n,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_sdi,
  output logic        dac_ld_n,
  output logic        busy,
  output logic        overrun
);

  localparam int             BW       = $clog2(FRAME_BITS);
  localparam logic [BW-1:0]  LAST_BIT = BW'(FRAME_BITS - 1);

  logic [1:0]            state;
  logic [FRAME_BITS-1:0] shreg;     // bits still to send, next one at MSB
  logic [BW-1:0]         bit_cnt;
  dac_sample_t           pend;
  logic                  pend_valid;

  dac_sample_t           new_sample;
  dac_sample_t           start_sample;
  logic [FRAME_BITS-1:0] start_cmd;
  logic                  start_go;

  logic                  div_en;
  logic                  half_done;
  logic                  sck_rise;
  logic                  sck_fall;

  // The divider also times the CS_HI and LDAC phases, one half-period each.
  assign div_en = (state != ST_IDLE);

  sck_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_divider (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .en        (div_en),
    .half_done (half_done),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall)
  );

  assign new_sample   = {shdn_n, data_in};
  // A waiting sample always goes first; in IDLE it is older than any load.
  assign start_sample = pend_valid ? pend : new_sample;
  assign start_cmd    = build_cmd(BUF, GA_N, start_sample);
  assign start_go     = (state == ST_IDLE) && (pend_valid || load);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ld_n   <= 1'b1;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            dac_cs_n <= 1'b0;
            dac_sck  <= 1'b0;
            dac_sdi  <= start_cmd[FRAME_BITS-1];
            shreg    <= {start_cmd[FRAME_BITS-2:0], 1'b0};
            bit_cnt  <= '0;
          end
          // Draining the pending slot frees it; a load in this same cycle
          // refills it rather than being lost.
          if (pend_valid) begin
            pend_valid <= load;
            if (load) pend <= new_sample;
          end
        end

        ST_SHIFT: begin
          if (sck_rise) dac_sck <= 1'b1;
          if (sck_fall) begin
            dac_sck <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state    <= ST_CS_HI;
              dac_cs_n <= 1'b1;
              dac_sdi  <= 1'b0;
            end else begin
              // Data moves only on the falling SCK edge, giving the DAC a
              // full half-period of setup before the next rising edge.
              bit_cnt <= bit_cnt + 1'b1;
              dac_sdi <= shreg[FRAME_BITS-1];
              shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end

        ST_CS_HI: begin
          if (half_done) begin
            state    <= ST_LDAC;
            dac_ld_n <= 1'b0;
          end
        end

        ST_LDAC: begin
          if (half_done) begin
            state    <= ST_IDLE;
            dac_ld_n <= 1'b1;
            busy     <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Mid-frame loads park in the pending slot; newest wins.
      if ((state != ST_IDLE) && load) begin
        pend       <= new_sample;
        pend_valid <= 1'b1;
        if (pend_valid) overrun <= 1'b1;
      end
    end
  end

endmodule
